// File: rtl/serial_subtractor_pkg.sv
// Shared types for the serial arithmetic family (subtractor today, more later).
package serial_arith_pkg;

   // IDLE: waiting for start; SHIFT: one operand bit consumed per clock.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

endpackage : serial_arith_pkg

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the serial subtractor.
//
// Handshake: the master raises start with op1/op2/borrow_in valid; the slave
// takes them on the first rising edge where start=1 and busy=0, then holds
// busy high until the result is ready. start while busy=1 is dropped (no
// queueing). done pulses for exactly one cycle when diff/borrow_out update;
// those two then hold until the next done. A start presented in the done
// cycle is accepted on the following edge.
interface serial_subtractor_if #(
   parameter int N = 4
);
   logic         start;
   logic         borrow_in;
   logic [N-1:0] op1;
   logic [N-1:0] op2;
   logic         busy;
   logic         done;
   logic [N-1:0] diff;
   logic         borrow_out;

   modport master (
      output start, borrow_in, op1, op2,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, borrow_in, op1, op2,
      output busy, done, diff, borrow_out
   );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_fs.sv
// Single-bit full subtractor: d = a - b - bin, bout set when a < b + bin.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and outgoing borrow of one bit position.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = op1 - op2 - borrow_in, LSB first,
// one bit per clock through a single full_subtractor cell.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus,
   output ser_state_t          dbg_state_o
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   ser_state_t    state_q, state_d;
   logic [N-1:0]  a_sr_q, a_sr_d;
   logic [N-1:0]  b_sr_q, b_sr_d;
   logic [N-1:0]  r_sr_q, r_sr_d;
   logic [N-1:0]  r_next;
   logic          brw_q, brw_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [N-1:0]  diff_q, diff_d;
   logic          bout_q, bout_d;
   logic          fs_d, fs_bout;

   full_subtractor u_fs (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (brw_q),
      .d    (fs_d),
      .bout (fs_bout)
   );

   // Next-state logic: load on start in IDLE, consume one bit per SHIFT edge,
   // publish the result only on the edge that handles bit N-1.
   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      r_sr_d  = r_sr_q;
      brw_d   = brw_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      diff_d  = diff_q;
      bout_d  = bout_q;
      // Result register with the current difference bit entering at the MSB.
      r_next         = r_sr_q >> 1;
      r_next[N-1]    = fs_d;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_sr_d  = bus.op1;
               b_sr_d  = bus.op2;
               brw_d   = bus.borrow_in;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d = a_sr_q >> 1;
            b_sr_d = b_sr_q >> 1;
            brw_d  = fs_bout;
            r_sr_d = r_next;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               diff_d  = r_next;
               bout_d  = fs_bout;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // All state, including the visible result, with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         r_sr_q  <= '0;
         brw_q   <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         r_sr_q  <= r_sr_d;
         brw_q   <= brw_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.diff       = diff_q;
   assign bus.borrow_out = bout_q;
   assign dbg_state_o    = state_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at N=4 (directed + exhaustive), N=1 and N=7
// (random). Expected {borrow_out,diff} is (op1-op2-bin) mod 2^(N+1).
module tb_serial_subtractor;
  import serial_arith_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.N(4)) if4 ();
  serial_subtractor_if #(.N(1)) if1 ();
  serial_subtractor_if #(.N(7)) if7 ();
  ser_state_t st4, st1, st7;

  serial_subtractor #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4), .dbg_state_o(st4));
  serial_subtractor #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .dbg_state_o(st1));
  serial_subtractor #(.N(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(if7), .dbg_state_o(st7));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  int done4_cnt = 0;
  logic [4:0] exp4_q[$];
  logic [1:0] exp1_q[$];
  logic [7:0] exp7_q[$];
  logic [4:0] e4;
  logic [1:0] e1;
  logic [7:0] e7;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic stray_done(input string name);
    checks++;
    errors++;
    $display("FAIL %s: done pulse with no pending operation", name);
  endtask

  // Monitors: pop expected result on every done pulse.
  always @(negedge clk) begin
    if (if4.done) begin
      done4_cnt++;
      if (exp4_q.size() == 0) stray_done("n4 done");
      else begin
        e4 = exp4_q.pop_front();
        check("n4 result", int'({if4.borrow_out, if4.diff}), int'(e4));
      end
    end
  end

  always @(negedge clk) begin
    if (if1.done) begin
      if (exp1_q.size() == 0) stray_done("n1 done");
      else begin
        e1 = exp1_q.pop_front();
        check("n1 result", int'({if1.borrow_out, if1.diff}), int'(e1));
      end
    end
  end

  always @(negedge clk) begin
    if (if7.done) begin
      if (exp7_q.size() == 0) stray_done("n7 done");
      else begin
        e7 = exp7_q.pop_front();
        check("n7 result", int'({if7.borrow_out, if7.diff}), int'(e7));
      end
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic issue4(input int a, input int b, input int bin);
    if4.start = 1'b1; if4.op1 = a[3:0]; if4.op2 = b[3:0]; if4.borrow_in = bin[0];
    exp4_q.push_back(5'(a - b - bin));
    @(negedge clk);
    if4.start = 1'b0;
  endtask

  task automatic issue1(input int a, input int b, input int bin);
    if1.start = 1'b1; if1.op1 = a[0]; if1.op2 = b[0]; if1.borrow_in = bin[0];
    exp1_q.push_back(2'(a - b - bin));
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  task automatic issue7(input int a, input int b, input int bin);
    if7.start = 1'b1; if7.op1 = a[6:0]; if7.op2 = b[6:0]; if7.borrow_in = bin[0];
    exp7_q.push_back(8'(a - b - bin));
    @(negedge clk);
    if7.start = 1'b0;
  endtask

  function automatic logic done_of(input int w);
    case (w)
      1:       return if1.done;
      7:       return if7.done;
      default: return if4.done;
    endcase
  endfunction

  // Waits (bounded) for done; cyc = falling edges waited.
  task automatic wait_done(input int w, output int cyc);
    cyc = 0;
    while (!done_of(w) && cyc < 3 * w + 10) begin
      @(negedge clk);
      cyc++;
    end
    if (!done_of(w)) begin
      checks++;
      errors++;
      $display("FAIL n%0d done timeout: waited %0d cycles, required done", w, cyc);
    end
  endtask

  // ---------------- stimulus ----------------
  int cyc;
  int snap;
  int a, b, bin;

  initial begin
    if4.start = 0; if4.op1 = 0; if4.op2 = 0; if4.borrow_in = 0;
    if1.start = 0; if1.op1 = 0; if1.op2 = 0; if1.borrow_in = 0;
    if7.start = 0; if7.op1 = 0; if7.op2 = 0; if7.borrow_in = 0;

    repeat (2) @(negedge clk);
    check("reset busy", int'(if4.busy), 0);
    check("reset done", int'(if4.done), 0);
    check("reset diff", int'(if4.diff), 0);
    check("reset borrow", int'(if4.borrow_out), 0);
    check("reset state", int'(st4), int'(IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // 5-3: busy right after load, done N cycles later, busy gone in done cycle
    issue4(5, 3, 0);
    check("n4 busy after load", int'(if4.busy), 1);
    wait_done(4, cyc);
    check("n4 latency", cyc, 4);
    check("n4 busy in done cycle", int'(if4.busy), 0);
    @(negedge clk);
    check("n4 done one cycle", int'(if4.done), 0);

    issue4(3, 5, 0); wait_done(4, cyc); @(negedge clk);
    issue4(0, 0, 1); wait_done(4, cyc); @(negedge clk);
    issue4(15, 15, 0); wait_done(4, cyc);
    repeat (6) begin
      @(negedge clk);
      check("n4 diff held", int'(if4.diff), 0);
      check("n4 borrow held", int'(if4.borrow_out), 0);
    end

    // start during an operation must be ignored
    issue4(5, 3, 0);
    if4.start = 1'b1; if4.op1 = 4'd9; if4.op2 = 4'd1; if4.borrow_in = 1'b0;
    @(negedge clk);
    if4.start = 1'b0;
    wait_done(4, cyc);
    @(negedge clk); #1;
    snap = done4_cnt;
    repeat (10) @(negedge clk);
    #1;
    check("n4 ignored start no extra done", done4_cnt, snap);
    check("n4 diff after ignored start", int'(if4.diff), 2);

    // reset mid-operation
    @(negedge clk);
    issue4(7, 2, 0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("n4 mid reset busy", int'(if4.busy), 0);
    check("n4 mid reset diff", int'(if4.diff), 0);
    check("n4 mid reset borrow", int'(if4.borrow_out), 0);
    check("n4 mid reset done", int'(if4.done), 0);
    exp4_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    issue4(4, 9, 1);
    wait_done(4, cyc);
    check("n4 latency after reset", cyc, 4);
    @(negedge clk);

    // exhaustive N=4, back-to-back starts in the done cycle
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++) begin
          issue4(i, j, k);
          wait_done(4, cyc);
          check("n4 b2b latency", cyc, 4);
        end
    @(negedge clk);

    // N=1: all cases, then random with random gaps
    for (int i = 0; i < 8; i++) begin
      issue1(i & 1, (i >> 1) & 1, (i >> 2) & 1);
      wait_done(1, cyc);
      check("n1 latency", cyc, 1);
    end
    repeat (30) begin
      issue1($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
      wait_done(1, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);

    // N=7: boundaries, then random
    issue7(0, 1, 0);   wait_done(7, cyc); check("n7 latency", cyc, 7);
    issue7(127, 0, 0); wait_done(7, cyc);
    issue7(0, 127, 1); wait_done(7, cyc);
    repeat (80) begin
      a = $urandom_range(0, 127);
      b = $urandom_range(0, 127);
      bin = $urandom_range(0, 1);
      issue7(a, b, bin);
      wait_done(7, cyc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (3) @(negedge clk);

    check("n4 pending results", exp4_q.size(), 0);
    check("n1 pending results", exp1_q.size(), 0);
    check("n7 pending results", exp7_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_serial_subtractor
